// File: rtl/mips_pkg.sv
// Shared types for the MIPS write-back path: default widths and the pending-queue entry.
// Latency: none; types and constants only.
// Backpressure: none; types and constants only.
package mips_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  // One queued MDU result. kill marks a result overtaken by a younger pipe write.
  typedef struct packed {
    logic              valid;
    logic              kill;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  // An entry still owes a real register write (r0 never counts).
  function automatic logic ent_live(input wb_ent_t e);
    return e.valid && !e.kill && (e.rd != '0);
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// In-order pending queue for MDU results, with kill-by-address and a live-register mask.
// Latency: an enqueued entry is visible at the head and in pend_mask the next cycle.
// Backpressure: full blocks enqueue even in a dequeue cycle; enq/deq are ignored when full/empty.
module wb_pend_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq,
  input  wb_ent_t               enq_ent,
  input  logic                  deq,
  input  logic                  kill_en,
  input  logic [REG_AW-1:0]     kill_rd,
  output wb_ent_t               head,
  output logic                  empty,
  output logic                  full,
  output logic [2**REG_AW-1:0]  pend_mask
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_ent_t          mem [DEPTH];
  logic [PTR_W-1:0] hd;
  logic [PTR_W-1:0] tl;
  logic [PTR_W:0]   cnt;
  logic             enq_ok;
  logic             deq_ok;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (PTR_W+1)'(DEPTH));
  assign enq_ok = enq && !full;
  assign deq_ok = deq && !empty;
  assign head   = mem[hd];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      if (enq_ok) tl <= tl + PTR_W'(1);
      if (deq_ok) hd <= hd + PTR_W'(1);
      case ({enq_ok, deq_ok})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage: kills hit only entries already queued, so a same-cycle enqueue stays live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].valid && (mem[i].rd == kill_rd)) mem[i].kill <= 1'b1;
      end
      if (deq_ok) mem[hd].valid <= 1'b0;
      if (enq_ok) mem[tl] <= enq_ent;
    end
  end

  // Registers with an outstanding queued write, for the hazard unit.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live(mem[i])) pend_mask[mem[i].rd] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the write-back stage and queued MDU results.
// Latency: pipe write 1 cycle; queued MDU >=2 cycles; MDU bypass (WB_ARB_BYPASS_EN) 1 cycle.
// Backpressure: mdu_ready drops when the queue is full; a starved queue forces a 1-cycle pipe_stall.
module wb_port_arbiter #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_AW     = mips_pkg::REG_AW,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_valid,
  input  logic [REG_AW-1:0]    pipe_rd,
  input  logic [DATA_W-1:0]    pipe_data,
  input  logic                 mdu_valid,
  input  logic [REG_AW-1:0]    mdu_rd,
  input  logic [DATA_W-1:0]    mdu_data,
  output logic                 mdu_ready,
  output logic                 pipe_stall,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**REG_AW-1:0] pend_mask
);
  import mips_pkg::*;

  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  wb_ent_t           enq_ent;
  wb_ent_t           head;
  logic              q_empty;
  logic              q_full;
  logic              grant_pipe;
  logic              grant_head;
  logic              grant_byp;
  logic              enq;
  logic              starve_hit;
  logic [SCNT_W-1:0] scnt;

  assign enq_ent = '{valid: 1'b1, kill: 1'b0, rd: mdu_rd, data: mdu_data};

  // Ready depends on registered occupancy only, never on this cycle's grant.
  assign mdu_ready = !q_full;

  // A stalled pipe hands its slot to the head; otherwise pipe first, then the queue.
  assign grant_head = head.valid && (pipe_stall || !pipe_valid);
  assign grant_pipe = !pipe_stall && pipe_valid;
`ifdef WB_ARB_BYPASS_EN
  assign grant_byp  = !pipe_stall && !pipe_valid && q_empty && mdu_valid;
`else
  assign grant_byp  = 1'b0;
`endif
  assign enq        = mdu_valid && mdu_ready && !grant_byp;
  assign starve_hit = !q_empty && !grant_head && (scnt == SCNT_W'(STARVE_MAX - 1));

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq),
    .enq_ent   (enq_ent),
    .deq       (grant_head),
    .kill_en   (grant_pipe && (pipe_rd != '0)),
    .kill_rd   (pipe_rd),
    .head      (head),
    .empty     (q_empty),
    .full      (q_full),
    .pend_mask (pend_mask)
  );

  // Count consecutive cycles the head waits; a hit raises the stall and restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt       <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= starve_hit;
      if (q_empty || grant_head || starve_hit) scnt <= '0;
      else                                     scnt <= scnt + SCNT_W'(1);
    end
  end

  // Register the granted write; r0 and killed entries consume the slot without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant_pipe) begin
      rf_we    <= (pipe_rd != '0);
      rf_waddr <= pipe_rd;
      rf_wdata <= pipe_data;
    end else if (grant_head) begin
      rf_we    <= !head.kill && (head.rd != '0);
      rf_waddr <= head.rd;
      rf_wdata <= head.data;
    end else if (grant_byp) begin
      rf_we    <= (mdu_rd != '0);
      rf_waddr <= mdu_rd;
      rf_wdata <= mdu_data;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
// Latency: checks every cycle on the falling edge; inputs change right after checking.
// Backpressure: the bench re-presents pipe writes during pipe_stall and holds MDU results until accepted.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
  localparam int DATA_W = 16, REG_AW = 3, DEPTH = 2, STARVE_MAX = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pipe_valid = 1'b0, mdu_valid = 1'b0;
  logic [REG_AW-1:0] pipe_rd = '0, mdu_rd = '0;
  logic [DATA_W-1:0] pipe_data = '0, mdu_data = '0;
  logic              mdu_ready, pipe_stall, rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [7:0]        pend_mask;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );

  // Reference model: pending results as a plain queue, starvation as a count of waiting cycles.
  typedef struct {int rd; int data; bit kill;} ment_t;
  ment_t mq[$];
  int    m_starve;
  bit    m_stall;
  bit    e_we;
  int    e_waddr, e_wdata;
  int    checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_mask();
    logic [7:0] m = '0;
    foreach (mq[i]) if (!mq[i].kill && mq[i].rd != 0) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_stall = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
  endtask

  task automatic model_step(input bit pv, input int prd, input int pdata,
                            input bit mv, input int mrd, input int mdata);
    bit    acc = mv && (mq.size() < DEPTH);
    bit    waiting = (mq.size() > 0);
    bit    served = 0;
    ment_t h;
    e_we = 0; e_waddr = 0; e_wdata = 0;
    if (waiting && (m_stall || !pv)) begin
      h = mq.pop_front();
      served = 1;
      e_we = !h.kill && h.rd != 0; e_waddr = h.rd; e_wdata = h.data;
    end else if (pv && !m_stall) begin
      e_we = (prd != 0); e_waddr = prd; e_wdata = pdata;
      if (prd != 0) foreach (mq[i]) if (mq[i].rd == prd) mq[i].kill = 1;
    end else if (BYP && acc && !m_stall) begin
      e_we = (mrd != 0); e_waddr = mrd; e_wdata = mdata;
      acc = 0;
    end
    if (acc) mq.push_back('{rd: mrd, data: mdata, kill: 1'b0});
    if (waiting && !served) m_starve++;
    else                    m_starve = 0;
    m_stall = 0;
    if (m_starve == STARVE_MAX) begin
      m_stall = 1;
      m_starve = 0;
    end
  endtask

  task automatic check_outputs();
    check("ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
    check("stall", 32'(pipe_stall), 32'(m_stall));
    check("mask", 32'(pend_mask), 32'(exp_mask()));
    check("we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      check("waddr", 32'(rf_waddr), e_waddr);
      check("wdata", 32'(rf_wdata), e_wdata);
    end
  endtask

  // Called on a falling edge: check this cycle, drive the next inputs, advance the model.
  task automatic step(input bit pv, input int prd, input int pdata,
                      input bit mv, input int mrd, input int mdata);
    check_outputs();
    pipe_valid = pv; pipe_rd = REG_AW'(prd); pipe_data = DATA_W'(pdata);
    mdu_valid  = mv; mdu_rd  = REG_AW'(mrd); mdu_data  = DATA_W'(mdata);
    model_step(pv, prd, pdata, mv, mrd, mdata);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pv = 0, mv = 0;
    int prd = 0, pdata = 0, mrd = 0, mdata = 0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(rf_we), 0);
    check("rst_waddr", 32'(rf_waddr), 0);
    check("rst_wdata", 32'(rf_wdata), 0);
    check("rst_stall", 32'(pipe_stall), 0);
    check("rst_mask", 32'(pend_mask), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(mdu_ready), 1);

    // Pipe-only writes, including r0.
    step(1, 3, 'h1234, 0, 0, 0);
    check("pipe_we", 32'(rf_we), 1);
    check("pipe_waddr", 32'(rf_waddr), 3);
    check("pipe_wdata", 32'(rf_wdata), 'h1234);
    step(1, 0, 'h5555, 0, 0, 0);
    check("pipe_r0_we", 32'(rf_we), 0);

    // MDU result queued behind a pipe write, drained in the next idle slot.
    step(1, 1, 'h0011, 1, 5, 'hBEEF);
    check("drain_mask5", 32'(pend_mask[5]), 1);
    step(0, 0, 0, 0, 0, 0);
    check("drain_we", 32'(rf_we), 1);
    check("drain_waddr", 32'(rf_waddr), 5);
    check("drain_wdata", 32'(rf_wdata), 'hBEEF);
    check("drain_mask5_clr", 32'(pend_mask[5]), 0);
    idle(2);

    // Fill the queue under continuous pipe traffic until starvation forces a stall.
    step(1, 1, 'h0101, 1, 6, 'h0A0A);
    step(1, 1, 'h0102, 1, 7, 'h0B0B);
    check("full_ready", 32'(mdu_ready), 0);
    step(1, 1, 'h0103, 1, 3, 'h0C0C);
    step(1, 1, 'h0104, 1, 3, 'h0C0C);
    check("starve_early", 32'(pipe_stall), 0);
    step(1, 1, 'h0105, 1, 3, 'h0C0C);
    check("starve_stall", 32'(pipe_stall), 1);
    step(1, 1, 'h0106, 1, 3, 'h0C0C);
    check("stall_drain_we", 32'(rf_we), 1);
    check("stall_drain_waddr", 32'(rf_waddr), 6);
    check("stall_drain_wdata", 32'(rf_wdata), 'h0A0A);
    check("stall_one_cycle", 32'(pipe_stall), 0);
    step(1, 1, 'h0106, 1, 3, 'h0C0C);
    check("held_pipe_waddr", 32'(rf_waddr), 1);
    check("held_pipe_wdata", 32'(rf_wdata), 'h0106);
    idle(5);

    // WAW kill: a later pipe write to r2 cancels the queued MDU result.
    step(1, 1, 'h0111, 1, 2, 'h00AA);
    check("waw_mask2", 32'(pend_mask[2]), 1);
    step(1, 2, 'h0007, 0, 0, 0);
    check("waw_mask2_clr", 32'(pend_mask[2]), 0);
    check("waw_pipe_wdata", 32'(rf_wdata), 'h0007);
    step(0, 0, 0, 0, 0, 0);
    check("waw_killed_we", 32'(rf_we), 0);
    // Same-cycle pipe write and enqueue to r4: the queued entry is younger and survives.
    step(1, 4, 'h1111, 1, 4, 'h2222);
    check("same_rd_mask4", 32'(pend_mask[4]), 1);
    step(0, 0, 0, 0, 0, 0);
    check("same_rd_we", 32'(rf_we), 1);
    check("same_rd_wdata", 32'(rf_wdata), 'h2222);
    idle(1);

    // Bypass into an empty queue with the pipe idle.
    step(0, 0, 0, 1, 4, 'h4444);
    check("byp_n1_we", 32'(rf_we), 32'(BYP));
    check("byp_mask4", 32'(pend_mask[4]), 32'(!BYP));
    step(0, 0, 0, 0, 0, 0);
    check("byp_n2_we", 32'(rf_we), 32'(!BYP));
    idle(1);

    // Reset in the middle of a drain: two entries queued, then reset.
    step(1, 1, 'h0201, 1, 5, 'h0505);
    step(1, 1, 'h0202, 1, 6, 'h0606);
    check("pre_rst_mask", 32'(pend_mask), 'h60);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(rf_we), 0);
    check("mid_rst_waddr", 32'(rf_waddr), 0);
    check("mid_rst_wdata", 32'(rf_wdata), 0);
    check("mid_rst_stall", 32'(pipe_stall), 0);
    check("mid_rst_mask", 32'(pend_mask), 0);
    pipe_valid = 1'b0; mdu_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("post_rst_ready", 32'(mdu_ready), 1);
    idle(4);

    // Random traffic obeying the hold rules for stalled pipe writes and unaccepted MDU results.
    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) begin
        pv = ($urandom_range(0, 9) < 6);
        prd = $urandom_range(0, 7);
        pdata = $urandom_range(0, 65535);
      end
      if (!(mv && mq.size() >= DEPTH)) begin
        mv = ($urandom_range(0, 9) < 4);
        mrd = $urandom_range(0, 7);
        mdata = $urandom_range(0, 65535);
      end
      step(pv, prd, pdata, mv, mrd, mdata);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port of the 16-bit MIPS core between the pipeline write-back result (the MemtoReg-selected data) and results from the multi-cycle multiply/divide unit (MDU). MDU results are held in a small pending queue and drained in idle write-back slots. A starvation counter forces a one-cycle pipeline stall when the queue has waited too long. The block sits between the write-back stage and the register file, and feeds a pending-register mask to the hazard unit.

## Interface
- DATA_W, 16, write data width
- REG_AW, 3, register address width (8 registers, r0 hard-wired zero)
- DEPTH, 2, pending-queue entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive denied cycles before a forced stall
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_valid  in  1  write-back stage has a register write this cycle
- pipe_rd  in  REG_AW  destination register
- pipe_data  in  DATA_W  write-back data (output of the MemtoReg mux)
- mdu_valid  in  1  MDU result available
- mdu_rd  in  REG_AW  MDU destination register
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  queue can accept; transfer when mdu_valid && mdu_ready
- pipe_stall  out  1  registered; pipeline holds write-back for this cycle
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  REG_AW  registered write address
- rf_wdata  out  DATA_W  registered write data
- pend_mask  out  2**REG_AW  bit i set while a live queued write to register i exists

## Operation
- Grant priority each cycle:
  - If pipe_stall=1, grant the queue head. Pipe input is not consumed; the pipeline re-presents it next cycle.
  - Otherwise, if pipe_valid, grant pipe.
  - Otherwise, if queue non-empty, grant the head.
  - Otherwise, grant the MDU bypass (see Configuration).
- Granted write goes to rf_we/rf_waddr/rf_wdata on the next edge. rf_we=0 if the granted address is 0 or the entry is killed.
- Queue is in-order FIFO. mdu_ready = (count < DEPTH), derived from registered count only, with no path from the grant. No enqueue while full, including in a cycle that dequeues.
- Enqueue and dequeue may occur in the same cycle; count is unchanged.
- WAW kill: a consumed pipe write with pipe_rd≠0 sets the kill bit on every queued entry with matching rd. Killed entries still drain through a slot but write nothing. A pipe write and an MDU enqueue to the same rd in the same cycle: the enqueued entry is younger and is not killed.
- pend_mask is the OR of live (valid, not killed, rd≠0) entries, registered alongside the queue.
- Starvation counter:
  - Increments each cycle the queue is non-empty and the head is not granted.
  - Clears on any head grant or when the queue is empty.
  - When it reaches STARVE_MAX-1, pipe_stall=1 on the next cycle, for exactly one cycle. The counter then clears.
- Reset (any time, including mid-drain): queue flushed, count=0, kill bits=0, counter=0. Outputs go to rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, pend_mask=0, and mdu_ready=1 immediately after deassertion. In-flight MDU results are discarded; the MDU is reset by the same rst_n.

## Timing
- Pipe write: input at cycle N → rf_we at N+1.
- MDU via queue:
  - Accepted at N, earliest head grant at N+1, rf_we at N+2.
  - Worst case waits STARVE_MAX+1 cycles after reaching the head.
- MDU bypass: accepted at N with an empty queue and no pipe_valid → rf_we at N+1; no queue entry is created.
- pend_mask bit sets the cycle after acceptance and clears the cycle after the head grant or kill.
- Throughput: one register write per cycle.

## Configuration
- WB_ARB_BYPASS_EN defined: bypass path as above.
- WB_ARB_BYPASS_EN undefined: every accepted MDU result is enqueued. Minimum MDU latency is 2 cycles, and pend_mask always covers the result for at least one cycle. The "otherwise bypass" grant case does not exist.

## Structure
- Shared package mips_pkg: DATA_W, REG_AW defaults, and the queue entry struct {valid, kill, rd, data}.
- Sub-module wb_pend_fifo: DEPTH-entry queue with count, head/tail pointers (wrapping modulo DEPTH), kill-by-address, and pend_mask generation.
- The top level holds grant logic, the starvation counter and the output registers.

## Test plan
- Reset mid-drain: 2 entries queued, assert rst_n=0 → all outputs 0 and pend_mask=0; after release mdu_ready=1 and no stale write ever appears.
- Pipe-only: pipe_valid rd=3 data=16'h1234 at N → rf_we=1, waddr=3, wdata=16'h1234 at N+1; rd=0 → rf_we=0.
- Queue drain: MDU rd=5 data=16'hBEEF accepted while pipe_valid=1, then pipe idle → write r5=16'hBEEF two cycles after acceptance; pend_mask[5] high in between.
- Full + starvation, DEPTH=2, STARVE_MAX=4: fill queue under continuous pipe_valid → mdu_ready=0; pipe_stall pulses once after 4 denied cycles, the head drains, and the held pipe write follows next cycle.
- WAW kill: queued MDU rd=2, then pipe write rd=2 data=16'h0007 → r2 final value 16'h0007, killed entry produces no rf_we, pend_mask[2] clears.
- Bypass: empty queue, pipe idle, MDU rd=4 at N → rf_we at N+1 with macro defined, at N+2 without.
